pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the MIPS fetch stage; successor to the plain loadable PC register. Holds the current PC and selects the next PC from sequential, branch, jump, jump-register, return and exception sources with fixed priority and stall support. Includes a small return-address stack (RAS) pushed on link jumps and popped on returns. Output `pc_out` drives instruction-memory addressing.

## Interface
- `WIDTH`, 32, PC width in bits (min 28)
- `RESET_VECTOR`, 0, PC value after reset
- `EXC_VECTOR`, 32'h0000_0180, PC loaded on exception or misaligned target (truncated to WIDTH)
- `RAS_DEPTH`, 4, return-stack entries (power of two, ≥2)

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hold PC and RAS
- `exception`  in  1  redirect to EXC_VECTOR
- `branch_taken`  in  1  take conditional branch
- `branch_offset`  in  WIDTH  sign-extended word offset
- `jump`  in  1  J/JAL
- `jump_target`  in  26  instruction-index field
- `jump_reg`  in  1  JR/JALR
- `reg_target`  in  WIDTH  register-file target
- `ret`  in  1  return: pop RAS for target
- `link`  in  1  with `jump` or `jump_reg`: push `pc_plus4`
- `pc_out`  out  WIDTH  current PC (registered)
- `pc_plus4`  out  WIDTH  `pc_out + 4` mod 2^WIDTH (combinational)
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries (registered)
- `ras_miss`  out  1  `ret` with empty RAS (combinational)
- `misaligned`  out  1  selected target bits [1:0] ≠ 0 (combinational)

## Operation
- Next-PC priority, highest first: reset → RESET_VECTOR; exception → EXC_VECTOR; stall → hold; ret → RAS top (or `reg_target` if empty); jump_reg → `reg_target`; jump → `{pc_plus4[WIDTH-1:28], jump_target, 2'b00}`; branch_taken → `pc_plus4 + (branch_offset << 2)`; else `pc_plus4`.
- All additions modulo 2^WIDTH; wrap-around silent.
- `misaligned` evaluated only for the ret/jump_reg source when not stalled and no exception; when high, PC loads EXC_VECTOR instead of the target, and no push/pop occurs.
- RAS push: `link` with the winning source being `jump` or `jump_reg`; pushes `pc_plus4` (no delay slot). Full RAS: circular overwrite of oldest entry, `ras_count` stays RAS_DEPTH.
- RAS pop: winning source `ret`, RAS non-empty; count decrements. Empty: target = `reg_target`, `ras_miss`=1, count stays 0.
- `link` ignored with `ret`, with branch/sequential, or when a higher-priority source wins.
- Stall or exception: no push, no pop. Exception does not clear RAS.

## Timing
- Reset values: `pc_out`=RESET_VECTOR, `ras_count`=0; RAS storage contents don't-care.
- Controls sampled at rising edge; `pc_out`/RAS update on that edge; single-cycle latency from control to new `pc_out`.
- `pc_plus4`, `ras_miss`, `misaligned` reflect current-cycle inputs/state with no register delay.
- Reset mid-operation (any state, including stall or full RAS) takes effect at the next edge, overriding all other inputs.

## Test plan
- Reset 2 cycles, then idle 3 cycles → `pc_out` 0x0, 0x4, 0x8, 0xC; `ras_count`=0.
- Load via jump_reg `reg_target`=0xFFFFFFFC, then idle → `pc_out` 0xFFFFFFFC then 0x00000000 (wrap).
- At PC 0x100, branch_taken with offset 0xFFFFFFFE → next `pc_out`=0xFC; with stall also high → holds 0x100.
- JAL from 0x200 (target 0x1000) then ret → PC 0x1000, then 0x204; `ras_count` 1→0.
- Five JALs from 0x10,0x20,…,0x50 with RAS_DEPTH=4, then five rets with `reg_target`=0x777C → pops 0x54,0x44,0x34,0x24, fifth ret `ras_miss`=1 and PC=0x777C.
- jump_reg with `reg_target`=0x302 → `misaligned`=1, PC=0x180; exception+stall together → PC=0x180; reset asserted with `ras_count`=3 → PC=0, count 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS fetch stage.
// Selects the next PC from reset, exception, stall, return, jump-register,
// jump, branch and sequential sources in that priority order. It also keeps
// a small circular return-address stack for link jumps and returns.
module pc_sequencer #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]       EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         exception,
  input  logic                         branch_taken,
  input  logic [WIDTH-1:0]             branch_offset,
  input  logic                         jump,
  input  logic [25:0]                  jump_target,
  input  logic                         jump_reg,
  input  logic [WIDTH-1:0]             reg_target,
  input  logic                         ret,
  input  logic                         link,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_miss,
  output logic                         misaligned
);

  localparam int unsigned      PW       = $clog2(RAS_DEPTH);
  localparam int unsigned      CW       = PW + 1;
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
  localparam logic [CW-1:0]    RAS_FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ras_ptr_q, ras_ptr_d;
  logic [CW-1:0]    ras_count_q, ras_count_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];

  logic             redirect_ok;
  logic             ras_empty;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] ind_target;
  logic [WIDTH-1:0] jump_pc;
  logic [WIDTH-1:0] branch_pc;
  logic             do_push;
  logic             do_pop;

  // Candidate targets and the alignment / stack-hit qualifiers for this cycle.
  always_comb begin
    pc_plus4          = pc_q + WIDTH'(4);
    redirect_ok       = !exception && !stall;
    ras_empty         = (ras_count_q == '0);
    ras_top           = ras_mem_q[ras_ptr_q - PW'(1)];
    ind_target        = (ret && !ras_empty) ? ras_top : reg_target;
    jump_pc           = pc_plus4;
    jump_pc[27:0]     = {jump_target, 2'b00};
    branch_pc         = pc_plus4 + (branch_offset << 2);
    misaligned        = redirect_ok && (ret || jump_reg) && (ind_target[1:0] != 2'b00);
    ras_miss          = redirect_ok && ret && ras_empty;
    do_push           = redirect_ok && !ret && link &&
                        (jump_reg ? !misaligned : jump);
    do_pop            = redirect_ok && ret && !ras_empty && !misaligned;
  end

  // Next-PC priority selection below reset.
  always_comb begin
    pc_d = pc_plus4;
    if (exception) begin
      pc_d = EXC_PC;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret || jump_reg) begin
      pc_d = misaligned ? EXC_PC : ind_target;
    end else if (jump) begin
      pc_d = jump_pc;
    end else if (branch_taken) begin
      pc_d = branch_pc;
    end
  end

  // Return stack: a push past full wraps and overwrites the oldest entry.
  always_comb begin
    ras_mem_d   = ras_mem_q;
    ras_ptr_d   = ras_ptr_q;
    ras_count_d = ras_count_q;
    if (do_push) begin
      ras_mem_d[ras_ptr_q] = pc_plus4;
      ras_ptr_d            = ras_ptr_q + PW'(1);
      ras_count_d          = (ras_count_q == RAS_FULL) ? ras_count_q : ras_count_q + CW'(1);
    end else if (do_pop) begin
      ras_ptr_d   = ras_ptr_q - PW'(1);
      ras_count_d = ras_count_q - CW'(1);
    end
  end

  // PC and stack bookkeeping registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      ras_ptr_q   <= '0;
      ras_count_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_count_q <= ras_count_d;
    end
  end

  // Stack storage needs no reset since the count marks valid entries.
  always_ff @(posedge clock) begin
    ras_mem_q <= ras_mem_d;
  end

  assign pc_out    = pc_q;
  assign ras_count = ras_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        exception = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic        ret = 1'b0;
  logic        link = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_miss;
  logic        misaligned;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_valid = 1'b0;

  pc_sequencer #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .exception(exception),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg),
    .reg_target(reg_target), .ret(ret), .link(link),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_count(ras_count),
    .ras_miss(ras_miss), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  // Records one comparison and reports it when it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Drives one cycle worth of controls just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic exc,
                               input logic br, input logic [31:0] boff,
                               input logic j, input logic [25:0] jt,
                               input logic jr, input logic [31:0] rt,
                               input logic r, input logic lk);
    @(posedge clock);
    #1;
    reset = rst; stall = st; exception = exc; branch_taken = br;
    branch_offset = boff; jump = j; jump_target = jt; jump_reg = jr;
    reg_target = rt; ret = r; link = lk;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_pc(input logic [31:0] addr);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, addr, 0, 0);
  endtask

  task automatic jal(input logic [31:0] target);
    applyStimulus(0, 0, 0, 0, 0, 1, target[27:2], 0, 0, 0, 1);
  endtask

  // Behavioural model and per-cycle comparison, evaluated on the falling edge.
  initial begin
    logic [31:0] tgt;
    logic        exp_mis;
    forever begin
      @(negedge clock);
      if (m_valid && !reset) begin
        checkOutput("pc_out", pc_out, m_pc);
        checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
        checkOutput("ras_count", 32'(ras_count), 32'(m_ras.size()));
        exp_mis = 1'b0;
        tgt = reg_target;
        if (ret && m_ras.size() > 0) tgt = m_ras[$];
        if (!exception && !stall && (ret || jump_reg)) exp_mis = (tgt[1:0] != 2'b00);
        checkOutput("misaligned", 32'(misaligned), 32'(exp_mis));
        if (!exception && !stall)
          checkOutput("ras_miss", 32'(ras_miss), 32'(ret && m_ras.size() == 0));
        else if (!ret || m_ras.size() > 0)
          checkOutput("ras_miss", 32'(ras_miss), 32'(0));
      end
      if (reset) begin
        m_pc = 32'h0;
        m_ras.delete();
        m_valid = 1'b1;
      end else if (m_valid) begin
        if (exception) m_pc = 32'h180;
        else if (stall) m_pc = m_pc;
        else if (ret) begin
          tgt = (m_ras.size() > 0) ? m_ras[$] : reg_target;
          if (tgt[1:0] != 2'b00) m_pc = 32'h180;
          else begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            m_pc = tgt;
          end
        end else if (jump_reg) begin
          if (reg_target[1:0] != 2'b00) m_pc = 32'h180;
          else begin
            if (link) begin
              m_ras.push_back(m_pc + 32'd4);
              if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = reg_target;
          end
        end else if (jump) begin
          if (link) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
          m_pc = {m_pc[31:28] + 4'((m_pc + 32'd4) >> 28) - m_pc[31:28], jump_target, 2'b00};
        end else if (branch_taken) m_pc = m_pc + 32'd4 + branch_offset * 32'd4;
        else m_pc = m_pc + 32'd4;
      end
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    logic [31:0] exp_pops [5];
    logic [31:0] rnd;
    logic [31:0] rt;
    int          off;
    exp_pops[0] = 32'h54; exp_pops[1] = 32'h44; exp_pops[2] = 32'h34;
    exp_pops[3] = 32'h24; exp_pops[4] = 32'h777C;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clock);
    checkOutput("reset pc", pc_out, 32'h0);
    checkOutput("reset ras_count", 32'(ras_count), 32'h0);
    idle(); @(negedge clock); checkOutput("seq pc 4", pc_out, 32'h4);
    idle(); @(negedge clock); checkOutput("seq pc 8", pc_out, 32'h8);
    idle(); @(negedge clock); checkOutput("seq pc C", pc_out, 32'hC);

    load_pc(32'hFFFF_FFFC);
    idle(); @(negedge clock); checkOutput("jr top", pc_out, 32'hFFFF_FFFC);
    idle(); @(negedge clock); checkOutput("wrap", pc_out, 32'h0);

    load_pc(32'h100);
    applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    @(negedge clock); checkOutput("at 0x100", pc_out, 32'h100);
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    @(negedge clock); checkOutput("stall hold", pc_out, 32'h100);
    idle(); @(negedge clock); checkOutput("branch back", pc_out, 32'hFC);

    load_pc(32'h200);
    jal(32'h1000);
    @(negedge clock); checkOutput("jal pc_plus4", pc_plus4, 32'h204);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 0);
    @(negedge clock);
    checkOutput("jal target", pc_out, 32'h1000);
    checkOutput("jal count", 32'(ras_count), 32'h1);
    idle(); @(negedge clock);
    checkOutput("ret target", pc_out, 32'h204);
    checkOutput("ret count", 32'(ras_count), 32'h0);

    for (int i = 1; i <= 5; i++) begin
      load_pc(32'(i * 16));
      jal(32'h1000);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h777C, 1, 0);
    @(negedge clock);
    checkOutput("full count", 32'(ras_count), 32'h4);
    checkOutput("ret1 miss", 32'(ras_miss), 32'h0);
    for (int k = 1; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h777C, 1, 0);
      @(negedge clock);
      checkOutput("pop pc", pc_out, exp_pops[k-1]);
      checkOutput("pop miss", 32'(ras_miss), (k == 4) ? 32'h1 : 32'h0);
    end
    idle(); @(negedge clock); checkOutput("miss pc", pc_out, exp_pops[4]);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h302, 0, 0);
    @(negedge clock); checkOutput("misaligned flag", 32'(misaligned), 32'h1);
    idle(); @(negedge clock); checkOutput("misaligned pc", pc_out, 32'h180);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); @(negedge clock); checkOutput("exc over stall", pc_out, 32'h180);

    jal(32'h2000); jal(32'h3000); jal(32'h4000);
    idle(); @(negedge clock); checkOutput("three pushes", 32'(ras_count), 32'h3);
    applyStimulus(1, 1, 0, 0, 0, 1, 26'h10, 0, 0, 0, 1);
    idle(); @(negedge clock);
    checkOutput("mid reset pc", pc_out, 32'h0);
    checkOutput("mid reset count", 32'(ras_count), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom();
      rt = {rnd[31:2], ($urandom_range(0, 7) == 0) ? rnd[1:0] : 2'b00};
      off = $urandom_range(0, 63) - 32;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                    32'(off), $urandom_range(0, 5) == 0, 26'($urandom()),
                    $urandom_range(0, 7) == 0, rt,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end
    idle();
    idle();
    @(negedge clock);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
